// File: rtl/step_pulse_sequencer_pkg.sv
// Shared types and constants for the step pulse sequencer: FSM state
// encoding, record field positions and default timing.
package step_pkg;

  localparam int RECORD_WIDTH               = 16;
  localparam int NUM_OUTPUTS                = 8;
  localparam int DEFAULT_PULSE_WIDTH_CYCLES = 12;
  localparam int DEFAULT_PERIOD_SCALE       = 4;

  localparam int MASK_MSB  = 15;
  localparam int MASK_LSB  = 8;
  localparam int DELAY_MSB = 7;
  localparam int DELAY_LSB = 0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    PULSE,
    GAP
  } state_e;

endpackage

// File: rtl/step_pulse_sequencer_if.sv
// FIFO-side handshake, step pins and status of the sequencer, with the
// FSM state exposed for observation.
interface step_pulse_sequencer_if;
  import step_pkg::*;

  // Pop handshake: fifo_read_en is a one-cycle strobe issued only when
  // fifo_empty was low in the deciding cycle; fifo_data is valid the cycle after.
  logic                    enable;
  logic                    fifo_empty;
  logic [RECORD_WIDTH-1:0] fifo_data;
  logic                    fifo_read_en;
  logic [NUM_OUTPUTS-1:0]  step_out;
  logic                    busy;
  logic [15:0]             records_done;
  state_e                  state;

  modport master (
    input  enable, fifo_empty, fifo_data,
    output fifo_read_en, step_out, busy, records_done, state
  );

  modport slave (
    output enable, fifo_empty, fifo_data,
    input  fifo_read_en, step_out, busy, records_done, state
  );

endinterface

// File: rtl/step_pulse_sequencer_down_counter.sv
// Loadable down counter that holds at zero and flags it.
module down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/step_pulse_sequencer.sv
// Pops one FIFO record at a time and plays it on the step pins as a
// fixed-width pulse followed by a scaled dwell.
module step_pulse_sequencer
  import step_pkg::*;
#(
  parameter int PULSE_WIDTH_CYCLES = DEFAULT_PULSE_WIDTH_CYCLES,
  parameter int PERIOD_SCALE       = DEFAULT_PERIOD_SCALE
) (
  input  logic                  clk,
  input  logic                  reset,
  step_pulse_sequencer_if.master bus
);

  localparam int DELAY_W = DELAY_MSB - DELAY_LSB + 1;
  localparam int PW_W    = $clog2(PULSE_WIDTH_CYCLES + 1);
  // One spare bit so (0xFF+1) << PERIOD_SCALE cannot overflow.
  localparam int GAP_W   = DELAY_W + PERIOD_SCALE + 1;
  localparam logic [PW_W-1:0] PULSE_LOAD = PW_W'(PULSE_WIDTH_CYCLES - 1);

  state_e                 r_state;
  state_e                 w_next_state;
  logic [NUM_OUTPUTS-1:0] r_mask;
  logic [NUM_OUTPUTS-1:0] r_step;
  logic [DELAY_W-1:0]     r_delay;
  logic                   r_read_en;
  logic                   r_busy;
  logic [15:0]            r_done;

  logic             w_start;
  logic             w_pulse_load;
  logic             w_pulse_dec;
  logic             w_pulse_zero;
  logic             w_gap_load;
  logic             w_gap_dec;
  logic             w_gap_zero;
  logic [GAP_W-1:0] w_gap_load_val;

  assign w_start        = bus.enable && !bus.fifo_empty;
  assign w_gap_load_val = ((GAP_W'(r_delay) + GAP_W'(1)) << PERIOD_SCALE) - GAP_W'(1);

  down_counter #(.WIDTH(PW_W)) u_pulse_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_pulse_load),
    .i_load_val (PULSE_LOAD),
    .i_dec      (w_pulse_dec),
    .o_zero     (w_pulse_zero)
  );

  down_counter #(.WIDTH(GAP_W)) u_gap_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_gap_load),
    .i_load_val (w_gap_load_val),
    .i_dec      (w_gap_dec),
    .o_zero     (w_gap_zero)
  );

  always_comb begin
    w_next_state = r_state;
    w_pulse_load = 1'b0;
    w_pulse_dec  = 1'b0;
    w_gap_load   = 1'b0;
    w_gap_dec    = 1'b0;
    case (r_state)
      IDLE:  if (w_start) w_next_state = FETCH;
      FETCH: w_next_state = LATCH;
      LATCH: begin
        w_next_state = PULSE;
        w_pulse_load = 1'b1;
      end
      PULSE: begin
        if (w_pulse_zero) begin
          w_next_state = GAP;
          w_gap_load   = 1'b1;
        end else begin
          w_pulse_dec = 1'b1;
        end
      end
      GAP: begin
        if (w_gap_zero) w_next_state = w_start ? FETCH : IDLE;
        else            w_gap_dec    = 1'b1;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each pin lines up with the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_mask    <= '0;
      r_delay   <= '0;
      r_step    <= '0;
      r_read_en <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= '0;
    end else begin
      r_state   <= w_next_state;
      r_read_en <= (w_next_state == FETCH);
      r_busy    <= (w_next_state != IDLE);
      if (r_state == LATCH) begin
        r_mask  <= bus.fifo_data[MASK_MSB:MASK_LSB];
        r_delay <= bus.fifo_data[DELAY_MSB:DELAY_LSB];
      end
      if (w_next_state == PULSE)
        r_step <= (r_state == LATCH) ? bus.fifo_data[MASK_MSB:MASK_LSB] : r_mask;
      else
        r_step <= '0;
      if ((r_state == GAP) && w_gap_zero) r_done <= r_done + 16'd1;
    end
  end

  assign bus.fifo_read_en = r_read_en;
  assign bus.step_out     = r_step;
  assign bus.busy         = r_busy;
  assign bus.records_done = r_done;
  assign bus.state        = r_state;

endmodule

// File: tb/tb_step_pulse_sequencer.sv
// Self-checking bench for step_pulse_sequencer: FIFO model, table vectors,
// randomized record streams against a trace model, and corner sequences.
module tb_step_pulse_sequencer;
  import step_pkg::*;

  localparam int OBS_W = 8 + 1 + 1 + 16;
  localparam int PW    = 12;
  localparam int SCALE = 16;

  typedef struct {
    logic [15:0] rec;
    logic [7:0]  mask;
    int          gap;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  step_pulse_sequencer_if bus();

  step_pulse_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int               n_vec = 0;
  int               n_err = 0;
  int               cyc   = 0;
  logic [15:0]      fifo_q[$];
  logic             prev_rd = 1'b0;
  logic [OBS_W-1:0] exp_q[$];
  logic [15:0]      exp_done = 16'd0;
  int               rise_q[$];
  logic [7:0]       prev_step = 8'd0;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Advance one clock; the FIFO model delivers a popped word the cycle after the strobe.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (prev_rd) begin
      if (fifo_q.size() > 0) bus.fifo_data = fifo_q.pop_front();
      else                   bus.fifo_data = 16'hDEAD;
    end
    prev_rd        = bus.fifo_read_en;
    bus.fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic fifo_push(input logic [15:0] rec);
    fifo_q.push_back(rec);
    bus.fifo_empty = 1'b0;
  endtask

  function automatic logic [OBS_W-1:0] obs(input logic [7:0] s, input logic rd,
                                           input logic b, input logic [15:0] d);
    return {s, rd, b, d};
  endfunction

  task automatic model_record(input logic [7:0] mask, input int gap);
    exp_q.push_back(obs(8'h00, 1'b1, 1'b1, exp_done));
    exp_q.push_back(obs(8'h00, 1'b0, 1'b1, exp_done));
    repeat (PW)  exp_q.push_back(obs(mask, 1'b0, 1'b1, exp_done));
    repeat (gap) exp_q.push_back(obs(8'h00, 1'b0, 1'b1, exp_done));
    exp_done++;
  endtask

  task automatic model_idle(input int n);
    repeat (n) exp_q.push_back(obs(8'h00, 1'b0, 1'b0, exp_done));
  endtask

  task automatic run_expected(input string name);
    logic [OBS_W-1:0] e;
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      if (bus.step_out != 8'h00 && prev_step == 8'h00) rise_q.push_back(cyc);
      prev_step = bus.step_out;
      chk(name, 32'({bus.step_out, bus.fifo_read_en, bus.busy, bus.records_done}), 32'(e));
    end
  endtask

  vec_t        tbl[7];
  int          n_rd;
  logic [15:0] d0;
  logic [7:0]  r_mask;
  logic [7:0]  r_delay;
  logic [15:0] rec;

  initial begin
    tbl[0] = '{16'h8103, 8'h81, 64};
    tbl[1] = '{16'hFF00, 8'hFF, 16};
    tbl[2] = '{16'h0100, 8'h01, 16};
    tbl[3] = '{16'h0200, 8'h02, 16};
    tbl[4] = '{16'h00FF, 8'h00, 4096};
    tbl[5] = '{16'hAA05, 8'hAA, 96};
    tbl[6] = '{16'h5A0F, 8'h5A, 256};

    reset          = 1'b1;
    bus.enable     = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_data  = 16'h0000;
    repeat (3) step();
    chk("rst_step_out", 32'(bus.step_out), 32'h0);
    chk("rst_read_en", 32'(bus.fifo_read_en), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_records_done", 32'(bus.records_done), 32'h0);
    chk("rst_state", 32'(bus.state), 32'(IDLE));
    reset = 1'b0;

    // Enabled but empty: nothing may be popped or driven.
    bus.enable = 1'b1;
    model_idle(100);
    run_expected("idle_empty");

    for (int i = 0; i < 7; i++) begin
      fifo_push(tbl[i].rec);
      model_record(tbl[i].mask, tbl[i].gap);
      model_idle(2);
      run_expected("table_trace");
    end

    // Three queued records back to back.
    d0 = exp_done;
    fifo_push(16'hFF00);
    fifo_push(16'h0100);
    fifo_push(16'h0200);
    model_record(8'hFF, 16);
    model_record(8'h01, 16);
    model_record(8'h02, 16);
    model_idle(2);
    rise_q.delete();
    run_expected("three_trace");
    chk("three_rises", 32'(rise_q.size()), 32'd3);
    if (rise_q.size() == 3) begin
      chk("three_spacing_a", 32'(rise_q[1] - rise_q[0]), 32'd30);
      chk("three_spacing_b", 32'(rise_q[2] - rise_q[1]), 32'd30);
    end
    chk("three_done", 32'(bus.records_done), 32'(d0 + 16'd3));

    // Randomized record streams against the trace model.
    for (int it = 0; it < 15; it++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        r_mask  = 8'($urandom_range(0, 255));
        r_delay = 8'($urandom_range(0, 12));
        rec     = {r_mask, r_delay};
        fifo_push(rec);
        model_record(r_mask, (int'(r_delay) + 1) * SCALE);
      end
      model_idle($urandom_range(1, 4));
      run_expected("random_trace");
    end

    // Drop enable during the first pulse: the second record must stay queued.
    d0 = exp_done;
    n_rd = 0;
    fifo_push(16'h1100);
    fifo_push(16'h2200);
    for (int i = 0; i < 45; i++) begin
      step();
      if (bus.fifo_read_en) n_rd++;
      if (i == 4) bus.enable = 1'b0;
      if (i == 5) chk("drop_pulse_mask", 32'(bus.step_out), 32'h11);
    end
    exp_done++;
    chk("drop_reads", 32'(n_rd), 32'd1);
    chk("drop_busy", 32'(bus.busy), 32'h0);
    chk("drop_done", 32'(bus.records_done), 32'(d0 + 16'd1));
    chk("drop_fifo_left", 32'(fifo_q.size()), 32'd1);
    fifo_q.delete();
    bus.fifo_empty = 1'b1;
    step();

    // Reset in the middle of a pulse.
    bus.enable = 1'b1;
    fifo_push(16'hAA05);
    repeat (5) step();
    chk("midpulse_step_out", 32'(bus.step_out), 32'hAA);
    chk("midpulse_busy", 32'(bus.busy), 32'h1);
    reset = 1'b1;
    step();
    chk("reset_step_out", 32'(bus.step_out), 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'h0);
    chk("reset_done", 32'(bus.records_done), 32'h0);
    chk("reset_state", 32'(bus.state), 32'(IDLE));
    chk("reset_read_en", 32'(bus.fifo_read_en), 32'h0);
    bus.enable = 1'b0;
    reset      = 1'b0;
    exp_done   = 16'd0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
